hex_line_tx: RTL and testbench

- Buffers 32-bit result words from the compute chain (negexp result, TSP best distance, RNG dump) in a small FIFO.
- Prints each word as one serial text line: 8 lowercase hex digits, most-significant nibble first, then '\n'.
- Drives the avr_interface tx_data/new_tx_data handshake directly.
- Replaces ad-hoc nibble printing in the top level, so the top level only pulses val_valid.

---
 rtl/hex_tx_pkg.sv | 15 +
 rtl/sync_fifo.sv | 42 ++++
 rtl/hex_line_tx.sv | 98 +++++++++
 tb/tb_hex_line_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_tx_pkg.sv
// Shared types and ASCII helpers for the serial hex line printer.
// The nibble converter is kept here so other debug printers can reuse it.
package hex_tx_pkg;

    typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

    localparam logic [7:0] NEWLINE     = 8'h0A;
    localparam logic [7:0] ASCII_DIGIT = 8'h30;
    localparam logic [7:0] ASCII_ALPHA = 8'h57;

    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        return (n < 4'd10) ? ASCII_DIGIT + {4'h0, n} : ASCII_ALPHA + {4'h0, n};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; full/empty come straight from the registered pointers.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wp, rp;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/hex_line_tx.sv
// Buffers 32-bit result words and prints each as "xxxxxxxx\n" over the avr_interface
// tx_data/new_tx_data handshake, one character every other cycle at best.
module hex_line_tx
    import hex_tx_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DIGITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] val,
    input  logic        val_valid,
    output logic [7:0]  tx_data,
    output logic        new_tx_data,
    input  logic        tx_busy,
    input  logic        tx_block,
    output logic        fifo_full,
    output logic        overflow,
    output logic        idle
);
    localparam int IW = $clog2(DIGITS + 1);

    state_t          state, state_n;
    logic [31:0]     shift, shift_n, head;
    logic [IW-1:0]   idx, idx_n;
    logic [7:0]      tx_data_n;
    logic            strobe_n, pop, full, empty;

    sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (val_valid),
        .din   (val),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign fifo_full = full;
    assign idle      = empty && (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shift       <= '0;
            idx         <= '0;
            tx_data     <= '0;
            new_tx_data <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            shift       <= shift_n;
            idx         <= idx_n;
            tx_data     <= tx_data_n;
            new_tx_data <= strobe_n;
            if (val_valid && full) overflow <= 1'b1;
        end
    end

    // HOLD gives avr_interface one cycle to raise tx_busy after each strobe.
    always_comb begin
        state_n   = state;
        shift_n   = shift;
        idx_n     = idx;
        tx_data_n = tx_data;
        strobe_n  = 1'b0;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    idx_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (!tx_busy && !tx_block) begin
                    tx_data_n = (idx == IW'(DIGITS)) ? NEWLINE : nib2ascii(shift[31:28]);
                    strobe_n  = 1'b1;
                    state_n   = HOLD;
                end
            end
            HOLD: begin
                if (idx == IW'(DIGITS)) begin
                    state_n = IDLE;
                end else begin
                    shift_n = {shift[27:0], 4'h0};
                    idx_n   = idx + 1'b1;
                    state_n = SEND;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hex_line_tx.sv
// Directed bench for hex_line_tx: captures every strobed character and compares lines,
// spacing, latency and status flags against hand-written expectations.
module tb_hex_line_tx;
    logic        clk = 1'b0, rst = 1'b1, val_valid = 1'b0, tx_busy = 1'b0, tx_block = 1'b0;
    logic [31:0] val = '0;
    logic [7:0]  tx_data;
    logic        new_tx_data, fifo_full, overflow, idle;

    int          n_err = 0, n_chk = 0, cyc = 0, last_t = 0;
    logic        prev_stb = 1'b0;
    logic [7:0]  rx[$];
    int          rx_t[$];

    logic [31:0] v3[6] = '{32'h01234567, 32'h89abcdef, 32'hcafef00d,
                           32'h13579bdf, 32'h2468ace0, 32'hdeadd00d};
    string       e3[5] = '{"01234567\n", "89abcdef\n", "cafef00d\n",
                           "13579bdf\n", "2468ace0\n"};

    always #5 clk = ~clk;

    hex_line_tx #(.DEPTH(4), .DIGITS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .val         (val),
        .val_valid   (val_valid),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy),
        .tx_block    (tx_block),
        .fifo_full   (fifo_full),
        .overflow    (overflow),
        .idle        (idle)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs move 2 time units after an edge; this samples at +1, i.e. the values seen by that edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (new_tx_data) begin
            chk("no_back_to_back", prev_stb, 1'b0);
            chk("strobe_while_busy", {tx_busy, tx_block}, 2'b00);
            rx.push_back(tx_data);
            rx_t.push_back(cyc);
        end
        prev_stb = new_tx_data;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] v, output int t);
        val       = v;
        val_valid = 1'b1;
        tick();
        val_valid = 1'b0;
        t         = cyc;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int b = budget;
        while (rx.size() < n && b > 0) begin
            tick();
            b--;
        end
        if (rx.size() < n) chk("timeout", rx.size(), n);
    endtask

    task automatic check_line(input string exp, input string tag, input bit gap, output int t0);
        int len = exp.len();
        int t, pt;
        logic [7:0] c;
        t0 = 0;
        pt = 0;
        wait_rx(len, 200);
        if (rx.size() < len) return;
        for (int i = 0; i < len; i++) begin
            c = rx.pop_front();
            t = rx_t.pop_front();
            chk($sformatf("%s_ch%0d", tag, i), c, exp[i]);
            if (i == 0) t0 = t;
            if (gap && i > 0) chk($sformatf("%s_gap%0d", tag, i), t - pt, 2);
            pt = t;
        end
        last_t = pt;
    endtask

    initial begin
        int t, t0, tl;

        tick(2);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_strobe", new_tx_data, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_full", fifo_full, 1'b0);
        chk("rst_idle", idle, 1'b1);
        rst = 1'b0;
        tick(2);

        // single line at full rate
        push(32'h0123ABCD, t);
        check_line("0123abcd\n", "l1", 1'b1, t0);
        chk("l1_latency", t0 - t, 2);
        tick(3);
        chk("l1_idle", idle, 1'b1);
        chk("l1_overflow", overflow, 1'b0);

        // back-to-back words
        val = 32'h00000000; val_valid = 1'b1;
        tick();
        t = cyc;
        val = 32'hFFFFFFFF;
        tick();
        val_valid = 1'b0;
        check_line("00000000\n", "l2a", 1'b1, t0);
        chk("l2a_latency", t0 - t, 2);
        tl = last_t;
        check_line("ffffffff\n", "l2b", 1'b1, t0);
        chk("l2_line_gap", t0 - tl, 3);
        tick(3);
        chk("l2_idle", idle, 1'b1);

        // fill while blocked, sixth push dropped
        tx_block = 1'b1;
        for (int i = 0; i < 6; i++) begin
            val = v3[i]; val_valid = 1'b1;
            tick();
        end
        val_valid = 1'b0;
        tick();
        chk("l3_full", fifo_full, 1'b1);
        chk("l3_overflow", overflow, 1'b1);
        chk("l3_no_output", rx.size(), 0);
        chk("l3_busy", idle, 1'b0);
        tx_block = 1'b0;
        for (int i = 0; i < 5; i++) check_line(e3[i], $sformatf("l3_%0d", i), 1'b1, t0);
        tick(20);
        chk("l3_extra_lines", rx.size(), 0);
        chk("l3_idle", idle, 1'b1);
        chk("l3_not_full", fifo_full, 1'b0);
        chk("l3_sticky", overflow, 1'b1);

        // tx_busy stall after third character
        push(32'hDEADBEEF, t);
        wait_rx(3, 100);
        tx_busy = 1'b1;
        tick(10);
        chk("l4_stalled", rx.size(), 3);
        tx_busy = 1'b0;
        check_line("deadbeef\n", "l4", 1'b0, t0);
        tick(3);
        chk("l4_idle", idle, 1'b1);

        // asynchronous reset while a strobe is high
        push(32'hAAAA5555, t);
        wait_rx(4, 100);
        chk("l5_pre_strobe", new_tx_data, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("l5_strobe_drop", new_tx_data, 1'b0);
        chk("l5_tx_data", tx_data, 8'h00);
        chk("l5_idle", idle, 1'b1);
        chk("l5_overflow", overflow, 1'b0);
        chk("l5_full", fifo_full, 1'b0);
        tick();
        rst = 1'b0;
        rx.delete();
        rx_t.delete();
        tick();
        push(32'h12345678, t);
        check_line("12345678\n", "l5", 1'b1, t0);
        chk("l5_latency", t0 - t, 2);

        // push while full in the same cycle as the IDLE pop
        tx_block = 1'b1;
        for (int i = 0; i < 5; i++) begin
            val = v3[i]; val_valid = 1'b1;
            tick();
        end
        val_valid = 1'b0;
        chk("l6_full", fifo_full, 1'b1);
        chk("l6_no_ovf", overflow, 1'b0);
        tx_block = 1'b0;
        wait_rx(9, 100);
        tick();
        chk("l6_full_before_pop", fifo_full, 1'b1);
        val = 32'h0BADF00D; val_valid = 1'b1;
        tick();
        val_valid = 1'b0;
        chk("l6_overflow", overflow, 1'b1);
        chk("l6_count_drop", fifo_full, 1'b0);
        for (int i = 0; i < 5; i++) check_line(e3[i], $sformatf("l6_%0d", i), 1'b1, t0);
        tick(30);
        chk("l6_dropped_word", rx.size(), 0);
        chk("l6_idle", idle, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
